// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Decode-side handshake between the fetch stage and instruction decode.
//   instr_valid   : fetch -> decode, an instruction is being offered
//   instr_ready   : decode -> fetch, decode accepts the offered instruction
//   instr_opcode  : fetched opcode byte
//   instr_operand : operand byte, zero for 1-byte instructions
//   instr_pc      : address of the offered opcode
// Modports: master (fetch side) and slave (decode side).
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_opcode;
    logic [DATA_W-1:0] instr_operand;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output instr_valid,
        output instr_opcode,
        output instr_operand,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_opcode,
        input  instr_operand,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage feeding decode, and the only producer of the
// program counter. The pc register downstream loads pc_next every cycle,
// so holding the PC means driving pc_q straight back.
// Instructions are 1 or 2 bytes; bit LONG_BIT of the opcode marks a
// trailing operand byte. Instruction memory is synchronous (data one
// cycle after imem_en).
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   pc_q / pc_next  : current PC in, next PC out (combinational)
//   imem_en/addr    : instruction memory read request
//   imem_rdata      : instruction memory read data
//   dec             : decode handshake (fetch_unit_if.master)
//   redirect_valid/redirect_pc : taken branch/jump, flushes the fetch
//   perf_instr_cnt / perf_stall_cnt : performance counters
// Optional feature: define FETCH_PERF_EN to build saturating counters of
// accepted instructions and back-pressure cycles; otherwise both counter
// outputs are tied to zero and no counter flops exist.
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int LONG_BIT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_q,
    output logic [ADDR_W-1:0] pc_next,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    fetch_unit_if.master      dec,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       perf_instr_cnt,
    output logic [15:0]       perf_stall_cnt
);

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_OPW  = 2'd1,
        S_ARGW = 2'd2,
        S_VAL  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] opcode_q, opcode_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              instr_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_OP;
            opcode_q  <= '0;
            operand_q <= '0;
            ipc_q     <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            ipc_q     <= ipc_d;
        end
    end

    // The PC only advances on an accepted handshake; every other cycle it
    // is held by feeding pc_q back. Redirect overrides everything except
    // reset, and suppresses any read since its data would be thrown away.
    // The combinational outputs are forced to zero while reset is held.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        operand_d   = operand_q;
        ipc_d       = ipc_q;
        imem_en     = 1'b0;
        imem_addr   = pc_q;
        pc_next     = pc_q;
        instr_valid = 1'b0;

        case (state_q)
            S_OP: begin
                imem_en = 1'b1;
                state_d = S_OPW;
            end
            S_OPW: begin
                opcode_d = imem_rdata;
                ipc_d    = pc_q;
                if (imem_rdata[LONG_BIT]) begin
                    imem_en   = 1'b1;
                    imem_addr = pc_q + ADDR_W'(1);
                    state_d   = S_ARGW;
                end else begin
                    operand_d = '0;
                    state_d   = S_VAL;
                end
            end
            S_ARGW: begin
                operand_d = imem_rdata;
                state_d   = S_VAL;
            end
            S_VAL: begin
                instr_valid = ~redirect_valid;
                if (instr_valid && dec.instr_ready) begin
                    pc_next = pc_q + (opcode_q[LONG_BIT] ? ADDR_W'(2) : ADDR_W'(1));
                    state_d = S_OP;
                end
            end
            default: state_d = S_OP;
        endcase

        if (redirect_valid) begin
            state_d   = S_OP;
            pc_next   = redirect_pc;
            imem_en   = 1'b0;
            imem_addr = pc_q;
            opcode_d  = opcode_q;
            operand_d = operand_q;
            ipc_d     = ipc_q;
        end

        if (!rst) begin
            pc_next     = '0;
            imem_en     = 1'b0;
            imem_addr   = '0;
            instr_valid = 1'b0;
        end
    end

    assign dec.instr_valid   = instr_valid;
    assign dec.instr_opcode  = opcode_q;
    assign dec.instr_operand = operand_q;
    assign dec.instr_pc      = ipc_q;

`ifdef FETCH_PERF_EN
    logic [15:0] instr_cnt_q, instr_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        instr_cnt_d = instr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (instr_valid && dec.instr_ready && (instr_cnt_q != 16'hFFFF)) begin
            instr_cnt_d = instr_cnt_q + 16'd1;
        end
        if (instr_valid && !dec.instr_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_instr_cnt = instr_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_instr_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Self-checking bench for fetch_unit. Models the downstream pc register
// and a synchronous 256-byte instruction ROM. Offered instructions are
// checked against a scoreboard of expected {opcode, operand, pc} records.
module tb_fetch_unit;

`ifdef FETCH_PERF_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] arg;
        logic [7:0] pc;
    } exp_t;

    typedef struct {
        logic [7:0] start_pc;
        logic [7:0] op;
        logic [7:0] arg;
        int         ready_delay;
        logic [7:0] exp_operand;
        logic [7:0] exp_next;
        int         exp_lat;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] pc_reg;
    logic [7:0] pc_next;
    logic       imem_en;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic [15:0] perf_instr_cnt;
    logic [15:0] perf_stall_cnt;

    logic [7:0] rom [256];
    exp_t       sb [$];
    int         vec_count;
    int         miss_count;
    int         model_instr;
    int         model_stall;

    fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) dec ();

    fetch_unit #(.ADDR_W(8), .DATA_W(8), .LONG_BIT(7)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_q           (pc_reg),
        .pc_next        (pc_next),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .dec            (dec),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .perf_instr_cnt (perf_instr_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream pc register: loads every cycle, no enable.
    always @(posedge clk or negedge rst) begin
        if (!rst) pc_reg <= 8'h00;
        else      pc_reg <= pc_next;
    end

    // Synchronous ROM, data one cycle after the enable.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= rom[imem_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are examined 1 time unit later.
    task automatic applyStimulus(input logic rv, input logic [7:0] rpc, input logic rdy);
        @(negedge clk);
        redirect_valid  = rv;
        redirect_pc     = rpc;
        dec.instr_ready = rdy;
        #1;
    endtask

    task automatic checkPerf(input string name);
        checkOutput({name, "_instr"}, perf_instr_cnt, PerfOn ? model_instr : 0);
        checkOutput({name, "_stall"}, perf_stall_cnt, PerfOn ? model_stall : 0);
    endtask

    // Scoreboard monitor: every handshake pops one expected record.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            model_instr = 0;
            model_stall = 0;
        end else if (dec.instr_valid) begin
            if (dec.instr_ready) begin
                model_instr++;
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected_instr", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("sb_opcode", dec.instr_opcode, e.op);
                    checkOutput("sb_operand", dec.instr_operand, e.arg);
                    checkOutput("sb_pc", dec.instr_pc, e.pc);
                end
            end else begin
                model_stall++;
            end
        end
    end

    // Called in the S_OP cycle of a fetch starting at 'start'; walks the
    // fetch to the accepted handshake and ends in the following S_OP cycle.
    task automatic issueAndAccept(input logic [7:0] start, input logic [7:0] op,
                                  input int exp_lat, input int ready_delay,
                                  input logic [7:0] exp_next);
        int         lat;
        bit         seen;
        logic [7:0] arg_addr;
        arg_addr = start + 8'd1;
        checkOutput("op_imem_en", imem_en, 1);
        checkOutput("op_imem_addr", imem_addr, start);
        checkOutput("op_pc_next", pc_next, start);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            applyStimulus(1'b0, 8'h00, ready_delay == 0);
            lat++;
            if (lat == 1) begin
                checkOutput("arg_imem_en", imem_en, exp_lat == 3);
                if (exp_lat == 3) checkOutput("arg_imem_addr", imem_addr, arg_addr);
            end
            if (dec.instr_valid) seen = 1'b1;
            else checkOutput("wait_pc_next", pc_next, start);
        end
        checkOutput("latency", lat, exp_lat);
        if (seen) begin
            for (int i = 0; i < ready_delay; i++) begin
                if (i > 0) applyStimulus(1'b0, 8'h00, 1'b0);
                checkOutput("stall_valid", dec.instr_valid, 1);
                checkOutput("stall_pc_next", pc_next, start);
                checkOutput("stall_imem_en", imem_en, 0);
                checkOutput("stall_opcode", dec.instr_opcode, op);
            end
            if (ready_delay > 0) applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("accept_valid", dec.instr_valid, 1);
            checkOutput("accept_pc_next", pc_next, exp_next);
            applyStimulus(1'b0, 8'h00, 1'b0);
            checkOutput("next_imem_en", imem_en, 1);
            checkOutput("next_imem_addr", imem_addr, exp_next);
        end
    endtask

    task automatic runVector(input vec_t v);
        logic [7:0] nxt;
        exp_t       e;
        nxt          = v.start_pc + 8'd1;
        rom[v.start_pc] = v.op;
        rom[nxt]     = v.arg;
        applyStimulus(1'b1, v.start_pc, 1'b0);
        checkOutput("redir_pc_next", pc_next, v.start_pc);
        checkOutput("redir_valid", dec.instr_valid, 0);
        e.op  = v.op;
        e.arg = v.exp_operand;
        e.pc  = v.start_pc;
        sb.push_back(e);
        applyStimulus(1'b0, 8'h00, v.ready_delay == 0);
        issueAndAccept(v.start_pc, v.op, v.exp_lat, v.ready_delay, v.exp_next);
    endtask

    vec_t vecs [7];

    initial begin
        exp_t e;
        int   stall_before;

        vecs[0] = '{8'h10, 8'h83, 8'h42, 0, 8'h42, 8'h12, 3};
        vecs[1] = '{8'hFF, 8'h90, 8'h7E, 0, 8'h7E, 8'h01, 3};
        vecs[2] = '{8'h20, 8'h05, 8'hAA, 0, 8'h00, 8'h21, 2};
        vecs[3] = '{8'h7F, 8'h7F, 8'h55, 0, 8'h00, 8'h80, 2};
        vecs[4] = '{8'h30, 8'h80, 8'h11, 5, 8'h11, 8'h32, 3};
        vecs[5] = '{8'hFE, 8'h01, 8'hEE, 0, 8'h00, 8'hFF, 2};
        vecs[6] = '{8'hFE, 8'hC3, 8'h99, 0, 8'h99, 8'h00, 3};

        vec_count   = 0;
        miss_count  = 0;
        model_instr = 0;
        model_stall = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0] = 8'h05;
        rst             = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 8'h00;
        dec.instr_ready = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_imem_en", imem_en, 0);
        checkOutput("rst_pc_next", pc_next, 0);
        checkOutput("rst_valid", dec.instr_valid, 0);
        checkOutput("rst_opcode", dec.instr_opcode, 0);
        checkOutput("rst_operand", dec.instr_operand, 0);
        checkOutput("rst_instr_pc", dec.instr_pc, 0);
        checkPerf("rst_perf");

        // First fetch out of reset: ROM[0]=05, 1-byte
        @(negedge clk);
        rst             = 1'b1;
        dec.instr_ready = 1'b1;
        #1;
        e = '{8'h05, 8'h00, 8'h00};
        sb.push_back(e);
        issueAndAccept(8'h00, 8'h05, 2, 0, 8'h01);
        checkPerf("first_perf");

        // Table-driven vectors
        foreach (vecs[i]) begin
            stall_before = perf_stall_cnt;
            runVector(vecs[i]);
            checkOutput("vec_stall_delta", perf_stall_cnt - stall_before[15:0],
                        PerfOn ? vecs[i].ready_delay : 0);
            checkPerf("vec_perf");
        end

        // Redirect while the operand read is in flight
        rom[8'h50] = 8'h83;
        rom[8'h51] = 8'h44;
        rom[8'h40] = 8'h05;
        applyStimulus(1'b1, 8'h50, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("ra_op_addr", imem_addr, 8'h50);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("ra_opw_addr", imem_addr, 8'h51);
        applyStimulus(1'b1, 8'h40, 1'b1);
        checkOutput("ra_redir_pc_next", pc_next, 8'h40);
        checkOutput("ra_redir_valid", dec.instr_valid, 0);
        e = '{8'h05, 8'h00, 8'h40};
        sb.push_back(e);
        applyStimulus(1'b0, 8'h00, 1'b1);
        issueAndAccept(8'h40, 8'h05, 2, 0, 8'h41);

        // Redirect coinciding with ready in S_VAL drops the instruction
        rom[8'h60] = 8'h05;
        rom[8'h70] = 8'h06;
        applyStimulus(1'b1, 8'h60, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rv_valid_before", dec.instr_valid, 1);
        applyStimulus(1'b1, 8'h70, 1'b1);
        checkOutput("rv_valid_masked", dec.instr_valid, 0);
        checkOutput("rv_pc_next", pc_next, 8'h70);
        e = '{8'h06, 8'h00, 8'h70};
        sb.push_back(e);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkPerf("rv_perf");
        issueAndAccept(8'h70, 8'h06, 2, 0, 8'h71);

        // Asynchronous reset while waiting for the operand
        rom[8'h90] = 8'h88;
        rom[8'h91] = 8'h12;
        applyStimulus(1'b1, 8'h90, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("ar_argw_en", imem_en, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ar_imem_en", imem_en, 0);
        checkOutput("ar_pc_next", pc_next, 0);
        checkOutput("ar_valid", dec.instr_valid, 0);
        checkOutput("ar_opcode", dec.instr_opcode, 0);
        checkOutput("ar_operand", dec.instr_operand, 0);
        checkOutput("ar_instr_pc", dec.instr_pc, 0);
        checkPerf("ar_perf");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("ar_release_en", imem_en, 1);
        checkOutput("ar_release_addr", imem_addr, 0);

        checkOutput("sb_leftover", sb.size(), 0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the 8-bit program counter register, and its only producer.
- Reads the current PC (pc register output) and fetches 1- or 2-byte instructions from a synchronous instruction ROM.
- Presents each instruction to decode through a valid/ready handshake.
- Drives the next-PC value back into the pc register's input.
- The pc register loads every cycle and has no enable, so this block holds the PC by driving the current value back.

Parameters:
ADDR_W, 8, PC and instruction-memory address width
DATA_W, 8, instruction byte width
LONG_BIT, 7, opcode bit index; when set, the instruction carries one operand byte

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset; only reset in the block
pc_q  input  ADDR_W  current PC from pc register
pc_next  output  ADDR_W  next PC, to pc register input; combinational
imem_en  output  1  instruction memory read enable
imem_addr  output  ADDR_W  instruction memory read address
imem_rdata  input  DATA_W  read data; valid exactly 1 cycle after the imem_en cycle
instr_valid  output  1  instruction offered to decode
instr_ready  input  1  decode accepts
instr_opcode  output  DATA_W  fetched opcode
instr_operand  output  DATA_W  operand byte; 0 for 1-byte instructions
instr_pc  output  ADDR_W  address of the offered opcode
redirect_valid  input  1  branch/jump taken; flush the fetch
redirect_pc  input  ADDR_W  redirect target
perf_instr_cnt  output  16  accepted-instruction count (optional feature)
perf_stall_cnt  output  16  back-pressure cycle count (optional feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - State S_OP.
  - instr_opcode, instr_operand, instr_pc, perf counters = 0.
  - instr_valid = 0, imem_en = 0, pc_next = 0.
- S_OP:
  - imem_en=1, imem_addr=pc_q, pc_next=pc_q.
  - Next state S_OPW.
- S_OPW (opcode on imem_rdata):
  - Register instr_opcode=imem_rdata and instr_pc=pc_q.
  - If imem_rdata[LONG_BIT]=1: this cycle imem_en=1, imem_addr=pc_q+1 (mod 2^ADDR_W); next state S_ARGW.
  - Otherwise: instr_operand<=0; next state S_VAL.
  - pc_next=pc_q.
- S_ARGW:
  - instr_operand<=imem_rdata.
  - Next state S_VAL.
  - pc_next=pc_q.
- S_VAL:
  - instr_valid = 1 & !redirect_valid. Opcode, operand and pc stay stable while waiting.
  - On instr_valid & instr_ready: pc_next = pc_q + len (len = 1 or 2, wraps mod 256); next state S_OP.
  - Otherwise: pc_next=pc_q; stay in S_VAL.
- instr_valid is low in every state except S_VAL.
- Latency from S_OP entry to instr_valid:
  - 2 cycles for a 1-byte instruction.
  - 3 cycles for a 2-byte instruction.
  - No back-to-back overlap; throughput is one instruction per 3 (1-byte) or 4 (2-byte) cycles.
- Redirect has priority in every state:
  - pc_next=redirect_pc; next state S_OP.
  - Any in-flight read data is discarded.
  - Registered instruction fields are left as-is (don't-care while instr_valid=0).
- Redirect in S_VAL in the same cycle as instr_ready=1: no handshake (instr_valid is masked); the instruction is dropped.
- Wrap-around: pc_q=8'hFF with a 2-byte opcode reads the operand at 8'h00 and gives pc_next=8'h01 on accept.
- Reset asserted mid-fetch: immediate return to reset values. After release, the first imem_en occurs on the first clock edge with rst=1.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - perf_instr_cnt increments on each instr_valid&instr_ready.
  - perf_stall_cnt increments on each cycle with instr_valid&!instr_ready.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: both ports remain and are tied to 0; no counter flops are generated.

Test Plan:
- Reset then release, pc_q=8'h00, ROM[0]=8'h05, ready=1 → imem_en/addr 0 at cycle 0; instr_valid at cycle 2 with opcode 05, operand 00, instr_pc 00; pc_next=8'h01 in that cycle.
- ROM[8'h10]=8'h83, ROM[8'h11]=8'h42, pc_q=8'h10 → instr_valid 3 cycles after S_OP with opcode 83, operand 42; pc_next=8'h12 on accept.
- Hold instr_ready=0 for 5 cycles in S_VAL → outputs stable, pc_next=pc_q throughout, no imem_en; perf_stall_cnt=5 with FETCH_PERF_EN.
- pc_q=8'hFF, ROM[FF]=8'h90, ROM[00]=8'h7E → operand read at addr 8'h00, operand 7E, pc_next=8'h01 on accept.
- redirect_valid=1, redirect_pc=8'h40 during S_ARGW → pc_next=8'h40; next cycle imem_addr=8'h40; the old instruction is never offered.
- redirect_valid and instr_ready both 1 in S_VAL → instr_valid=0, pc_next=redirect_pc, perf_instr_cnt unchanged; async reset mid-S_ARGW → all outputs zero immediately.
